// File: rtl/tis_debug_ocimem_engine.sv
// Purpose: turns JTAG debug-module command strobes into single-word accesses on a local debug memory port.
// Latency: write strobe to monitor_ready in 2 cycles; read strobe to MonDReg and monitor_ready in 3 cycles (zero-wait slave).
// Backpressure: requests are held while mem_waitrequest is high, bounded by TIMEOUT_CYCLES; strobes that arrive while busy are dropped and flagged.
module tis_debug_ocimem_engine #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADDEAD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_REQ  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LIM = TIMEOUT_CYCLES[15:0];

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       tmo_cnt;
    logic [15:0]       tmo_cnt_inc;
    logic              tmo_hit;
    logic              any_strobe;
    logic              unused_jdo;

    assign tmo_cnt_inc = tmo_cnt + 16'd1;
    // Compared on the incremented value so the abort lands on the edge ending the last allowed busy cycle.
    assign tmo_hit     = (tmo_cnt_inc >= TMO_LIM);
    assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign mem_address = addr;
    assign unused_jdo  = ^jdo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr          <= '0;
            tmo_cnt       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_action_ocimem_a) begin
                        addr <= jdo[ADDR_W-1:0];
                        if (jdo[36]) begin
                            monitor_error <= 1'b0;
                        end
                        if (jdo[37]) begin
                            state         <= ST_RD_REQ;
                            mem_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                            tmo_cnt       <= '0;
                        end
                    end else if (take_action_ocimem_b) begin
                        mem_writedata <= jdo[31:0];
                        state         <= ST_WR_REQ;
                        mem_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        tmo_cnt       <= '0;
                    end else if (take_no_action_ocimem_a) begin
                        state         <= ST_RD_REQ;
                        mem_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        tmo_cnt       <= '0;
                    end
                end

                ST_RD_REQ: begin
                    tmo_cnt <= tmo_cnt_inc;
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (!mem_waitrequest && mem_readdatavalid) begin
                        mem_read      <= 1'b0;
                        MonDReg       <= mem_readdata;
                        addr          <= addr + 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (tmo_hit) begin
                        mem_read      <= 1'b0;
                        MonDReg       <= ERR_DATA;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    tmo_cnt <= tmo_cnt_inc;
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (mem_readdatavalid) begin
                        MonDReg       <= mem_readdata;
                        addr          <= addr + 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (tmo_hit) begin
                        MonDReg       <= ERR_DATA;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                ST_WR_REQ: begin
                    tmo_cnt <= tmo_cnt_inc;
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (!mem_waitrequest) begin
                        mem_write     <= 1'b0;
                        addr          <= addr + 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (tmo_hit) begin
                        mem_write     <= 1'b0;
                        MonDReg       <= ERR_DATA;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tis_debug_ocimem_engine.sv
// Directed bench for tis_debug_ocimem_engine: hand-computed expectations, one cycle at a time.
module tb_tis_debug_ocimem_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;

    int n_vec = 0;
    int n_err = 0;

    tis_debug_ocimem_engine #(
        .ADDR_W        (8),
        .TIMEOUT_CYCLES(255),
        .ERR_DATA      (32'hDEADDEAD)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .jdo                    (jdo),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .mem_address            (mem_address),
        .mem_read               (mem_read),
        .mem_write              (mem_write),
        .mem_writedata          (mem_writedata),
        .mem_readdata           (mem_readdata),
        .mem_waitrequest        (mem_waitrequest),
        .mem_readdatavalid      (mem_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] payload);
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        jdo                     = payload;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo                     = '0;
    endtask

    initial begin
        reset                   = 1'b1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo                     = '0;
        mem_readdata            = '0;
        mem_waitrequest         = 1'b0;
        mem_readdatavalid       = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_mondreg", MonDReg, 0);
        chk("rst_ready",   monitor_ready, 1);
        chk("rst_error",   monitor_error, 0);
        chk("rst_read",    mem_read, 0);
        chk("rst_write",   mem_write, 0);
        chk("rst_addr",    mem_address, 0);
        chk("rst_wdata",   mem_writedata, 0);

        // Address load without read, then a plain read at that address
        strobe(1'b1, 1'b0, 1'b0, 38'h00_0000_0010);
        chk("load_ready", monitor_ready, 1);
        chk("load_addr",  mem_address, 8'h10);
        chk("load_noread", mem_read, 0);
        strobe(1'b0, 1'b0, 1'b1, 38'h0);
        chk("rd1_req",   mem_read, 1);
        chk("rd1_busy",  monitor_ready, 0);
        chk("rd1_addr",  mem_address, 8'h10);
        tick();
        chk("rd1_dropreq", mem_read, 0);
        chk("rd1_wait",    monitor_ready, 0);
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h12345678;
        tick();
        mem_readdatavalid = 1'b0;
        chk("rd1_data",  MonDReg, 32'h12345678);
        chk("rd1_ready", monitor_ready, 1);
        chk("rd1_inc",   mem_address, 8'h11);

        // Write burst: first write stalled for three cycles
        mem_waitrequest = 1'b1;
        strobe(1'b0, 1'b1, 1'b0, 38'h00_A5A5_A5A5);
        chk("wr1_wdata", mem_writedata, 32'hA5A5A5A5);
        chk("wr1_addr",  mem_address, 8'h11);
        for (int i = 0; i < 3; i++) begin
            chk("wr1_stall_write", mem_write, 1);
            chk("wr1_stall_ready", monitor_ready, 0);
            tick();
        end
        mem_waitrequest = 1'b0;
        chk("wr1_held", mem_write, 1);
        tick();
        chk("wr1_done_write", mem_write, 0);
        chk("wr1_done_ready", monitor_ready, 1);
        chk("wr1_inc",        mem_address, 8'h12);
        chk("wr1_error",      monitor_error, 0);
        strobe(1'b0, 1'b1, 1'b0, 38'h00_5A5A_5A5A);
        chk("wr2_write", mem_write, 1);
        chk("wr2_wdata", mem_writedata, 32'h5A5A5A5A);
        chk("wr2_addr",  mem_address, 8'h12);
        tick();
        chk("wr2_done_ready", monitor_ready, 1);
        chk("wr2_inc",        mem_address, 8'h13);
        chk("wr2_error",      monitor_error, 0);

        // Wrap: load 0xFF with read, next read goes to 0x00
        strobe(1'b1, 1'b0, 1'b0, 38'h20_0000_00FF);
        chk("wrap_req",  mem_read, 1);
        chk("wrap_addr", mem_address, 8'hFF);
        tick();
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'hCAFEF00D;
        tick();
        mem_readdatavalid = 1'b0;
        chk("wrap_data", MonDReg, 32'hCAFEF00D);
        chk("wrap_to0",  mem_address, 8'h00);
        // Read where readdatavalid coincides with acceptance
        strobe(1'b0, 1'b0, 1'b1, 38'h0);
        chk("fast_addr", mem_address, 8'h00);
        chk("fast_req",  mem_read, 1);
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h0BADBEEF;
        tick();
        mem_readdatavalid = 1'b0;
        chk("fast_data",  MonDReg, 32'h0BADBEEF);
        chk("fast_ready", monitor_ready, 1);
        chk("fast_noreq", mem_read, 0);
        chk("fast_inc",   mem_address, 8'h01);

        // Overrun during RD_WAIT
        strobe(1'b0, 1'b0, 1'b1, 38'h0);
        tick();
        strobe(1'b0, 1'b0, 1'b1, 38'h0);
        chk("ovr_error", monitor_error, 1);
        chk("ovr_busy",  monitor_ready, 0);
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h11112222;
        tick();
        mem_readdatavalid = 1'b0;
        chk("ovr_data",   MonDReg, 32'h11112222);
        chk("ovr_sticky", monitor_error, 1);
        chk("ovr_addr",   mem_address, 8'h02);
        strobe(1'b1, 1'b0, 1'b0, 38'h10_0000_0040);
        chk("clr_error", monitor_error, 0);
        chk("clr_addr",  mem_address, 8'h40);

        // Priority: ocimem_a beats ocimem_b in the same cycle
        strobe(1'b1, 1'b1, 1'b0, 38'h00_0000_0080);
        chk("pri_nowrite", mem_write, 0);
        chk("pri_ready",   monitor_ready, 1);
        chk("pri_addr",    mem_address, 8'h80);
        chk("pri_wdata",   mem_writedata, 32'h5A5A5A5A);
        tick();
        chk("pri_nowrite2", mem_write, 0);

        // Timeout: readdatavalid never arrives
        strobe(1'b0, 1'b0, 1'b1, 38'h0);
        for (int i = 0; i < 254; i++) tick();
        chk("tmo_pre_ready", monitor_ready, 0);
        chk("tmo_pre_error", monitor_error, 0);
        tick();
        chk("tmo_ready",  monitor_ready, 1);
        chk("tmo_error",  monitor_error, 1);
        chk("tmo_data",   MonDReg, 32'hDEADDEAD);
        chk("tmo_noread", mem_read, 0);
        chk("tmo_addr",   mem_address, 8'h80);
        strobe(1'b1, 1'b0, 1'b0, 38'h10_0000_0020);
        chk("tmo_clr", monitor_error, 0);

        // Reset while a write is held under waitrequest
        mem_waitrequest = 1'b1;
        strobe(1'b0, 1'b1, 1'b0, 38'h00_0000_0077);
        tick();
        chk("rstw_held", mem_write, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        chk("rstw_write", mem_write, 0);
        chk("rstw_ready", monitor_ready, 1);
        chk("rstw_addr",  mem_address, 8'h00);
        chk("rstw_wdata", mem_writedata, 0);
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h99999999;
        tick();
        mem_readdatavalid = 1'b0;
        chk("late_rdv_data",  MonDReg, 0);
        chk("late_rdv_ready", monitor_ready, 1);
        chk("late_rdv_addr",  mem_address, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
